// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and defaults for the UART transmit arbiter.
//   state_t           - arbiter FSM encoding
//   DATA_W_DEF        - default byte width
//   START_TIMEOUT_DEF - default cycles to wait for tx_busy before re-pulsing tx_start
//   id_w()            - requester index width, at least 1 bit so NUM_REQ=1 still works
package uart_arb_pkg;
   typedef enum logic [2:0] {ARB, HOLD, START, WAIT_BUSY, WAIT_DONE} state_t;
   localparam int DATA_W_DEF = 8;
   localparam int START_TIMEOUT_DEF = 15;
   function automatic int id_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus plus transmitter handshake for the UART arbiter.
//   req_valid/req_data/req_last/req_ready - NUM_REQ byte sources, byte i at [i*DATA_W +: DATA_W]
//   tx_data/tx_start/tx_busy              - link to uart_tx_module
//   grant_id/locked                       - arbitration status
//   master: the arbiter side; slave: requesters and transmitter side
interface uart_tx_arbiter_if import uart_arb_pkg::*; #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W = DATA_W_DEF
) ();
   localparam int ID_W = id_w(NUM_REQ);
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0] req_last;
   logic [NUM_REQ-1:0] req_ready;
   logic [DATA_W-1:0] tx_data;
   logic tx_start;
   logic tx_busy;
   logic [ID_W-1:0] grant_id;
   logic locked;
   modport master (
      input req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_data, tx_start, grant_id, locked
   );
   modport slave (
      output req_valid, req_data, req_last, tx_busy,
      input req_ready, tx_data, tx_start, grant_id, locked
   );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req       in  NUM_REQ  request vector
//   ptr       in  ID_W     highest-priority index
//   win       out ID_W     first set request at or after ptr, wrapping modulo NUM_REQ
//   any_valid out 1        some request is set
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int ID_W = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    win,
   output logic               any_valid
);
   logic [ID_W-1:0] idx;
   // scan from the farthest offset back to ptr so the nearest set request wins last
   always_comb begin
      idx = '0;
      win = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (req[idx]) win = idx;
      end
   end
   assign any_valid = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte sources.
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   bus   master modport of uart_tx_arbiter_if (requesters, tx link, grant status)
// A grant stays locked to one requester until it sends a byte marked last.
module uart_tx_arbiter import uart_arb_pkg::*; #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W = DATA_W_DEF,
   parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
   input logic clk,
   input logic rst_n,
   uart_tx_arbiter_if.master bus
);
   localparam int ID_W = id_w(NUM_REQ);
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);
   state_t state, state_d;
   logic [ID_W-1:0] rr_ptr, win, sel;
   logic any_valid, accept, last_q;
   logic [CNT_W-1:0] cnt;
   rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req(bus.req_valid),
      .ptr(rr_ptr),
      .win(win),
      .any_valid(any_valid)
   );
   always_comb begin
      state_d = state;
      accept = 1'b0;
      sel = bus.grant_id;
      bus.tx_start = 1'b0;
      case (state)
         ARB: begin
            sel = win;
            accept = any_valid;
         end
         HOLD: accept = bus.req_valid[bus.grant_id];
         START: begin
            bus.tx_start = !bus.tx_busy;
            state_d = bus.tx_busy ? START : WAIT_BUSY;
         end
         WAIT_BUSY: state_d = bus.tx_busy ? WAIT_DONE :
                              (cnt == CNT_W'(START_TIMEOUT - 1)) ? START : WAIT_BUSY;
         WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : (last_q ? ARB : HOLD);
         default: state_d = ARB;
      endcase
      if (accept) state_d = START;
      bus.req_ready = accept ? NUM_REQ'(1) << sel : '0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ARB;
         rr_ptr <= '0;
         last_q <= 1'b0;
         cnt <= '0;
         bus.grant_id <= '0;
         bus.locked <= 1'b0;
         bus.tx_data <= '0;
      end else begin
         state <= state_d;
         // counts WAIT_BUSY cycles; zero whenever we are elsewhere, so entry starts at 0
         cnt <= (state == WAIT_BUSY) ? cnt + 1'b1 : '0;
         if (accept) begin
            bus.grant_id <= sel;
            bus.tx_data <= bus.req_data[sel*DATA_W +: DATA_W];
            last_q <= bus.req_last[sel];
            bus.locked <= 1'b1;
         end
         if (state == WAIT_DONE && !bus.tx_busy && last_q) begin
            bus.locked <= 1'b0;
            rr_ptr <= (int'(bus.grant_id) == NUM_REQ - 1) ? '0 : bus.grant_id + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven and sequence checks of uart_tx_arbiter with a uart_tx_module model.
module tb_uart_tx_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tb_busy = 1'b0;
   logic model_en = 1'b0;
   int busy_cnt = 0;
   int vectors = 0;
   int fails = 0;
   logic [7:0] sent[$];
   uart_tx_arbiter_if #(.NUM_REQ(3), .DATA_W(8)) bus ();
   uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8), .START_TIMEOUT(15)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   assign bus.tx_busy = tb_busy | (busy_cnt > 0);
   // transmitter model: busy rises the cycle after a start pulse and holds 20 cycles
   always @(posedge clk) begin
      if (model_en && bus.tx_start) busy_cnt <= 20;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (bus.tx_start) sent.push_back(bus.tx_data);
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   typedef struct {
      logic rst_n;
      logic [2:0] valid;
      logic [2:0] last;
      logic busy;
      logic [2:0] ready;
      logic start;
      logic [7:0] data;
      logic [1:0] gid;
      logic locked;
   } vec_t;
   vec_t tbl[$];
   function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [2:0] l, input logic b,
                               input logic [2:0] rd, input logic s, input logic [7:0] d,
                               input logic [1:0] g, input logic lk);
      vec_t t;
      t.rst_n = r; t.valid = v; t.last = l; t.busy = b;
      t.ready = rd; t.start = s; t.data = d; t.gid = g; t.locked = lk;
      return t;
   endfunction
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_last = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sent.delete();
   endtask
   task automatic wait_ready(input int idx, input int budget, input string name);
      bit got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         #1;
         if (bus.req_ready[idx]) got = 1'b1;
         @(negedge clk);
      end
      vectors++;
      if (!got) begin
         fails++;
         $display("FAIL %s: req_ready[%0d] not seen within %0d cycles", name, idx, budget);
      end
   endtask
   task automatic wait_sent(input int n, input int budget, input string name);
      bit ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (sent.size() >= n) ok = 1'b1;
      end
      vectors++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: %0d bytes sent, expected %0d within %0d cycles", name, sent.size(), n, budget);
      end
   endtask
   task automatic wait_idle(input int budget, input string name);
      bit ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         #1;
         if (!bus.locked && !bus.tx_busy) ok = 1'b1;
      end
      vectors++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: still locked=%0b busy=%0b after %0d cycles", name, bus.locked, bus.tx_busy, budget);
      end
   endtask
   function automatic logic [7:0] sent_at(input int i);
      return (sent.size() > i) ? sent[i] : 8'hxx;
   endfunction
   initial begin
      logic [7:0] fair_exp[6];
      logic [7:0] lock_exp[4];
      fair_exp = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43};
      lock_exp = '{8'h41, 8'h42, 8'h43, 8'h30};
      bus.req_valid = '0;
      bus.req_last = '0;
      bus.req_data = {8'h43, 8'h42, 8'h41};
      // single byte, busy held off at START, wrap of rr_ptr, reset mid-transfer, HOLD
      tbl.push_back(mk(0, 3'b000, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 3'b001, 3'b001, 0, 3'b001, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 1, 8'h41, 0, 1));
      tbl.push_back(mk(1, 3'b000, 3'b000, 1, 3'b000, 0, 8'h41, 0, 1));
      tbl.push_back(mk(1, 3'b000, 3'b000, 1, 3'b000, 0, 8'h41, 0, 1));
      tbl.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, 8'h41, 0, 1));
      tbl.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, 8'h41, 0, 0));
      tbl.push_back(mk(1, 3'b100, 3'b100, 1, 3'b100, 0, 8'h41, 0, 0));
      tbl.push_back(mk(1, 3'b000, 3'b000, 1, 3'b000, 0, 8'h43, 2, 1));
      tbl.push_back(mk(1, 3'b000, 3'b000, 1, 3'b000, 0, 8'h43, 2, 1));
      tbl.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 1, 8'h43, 2, 1));
      tbl.push_back(mk(1, 3'b000, 3'b000, 1, 3'b000, 0, 8'h43, 2, 1));
      tbl.push_back(mk(1, 3'b000, 3'b000, 0, 3'b000, 0, 8'h43, 2, 1));
      tbl.push_back(mk(1, 3'b011, 3'b011, 0, 3'b001, 0, 8'h43, 2, 0));
      tbl.push_back(mk(1, 3'b011, 3'b011, 0, 3'b000, 1, 8'h41, 0, 1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 0, 3'b000, 0, 8'h41, 0, 1));
      tbl.push_back(mk(0, 3'b000, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 3'b110, 3'b000, 0, 3'b010, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 3'b110, 3'b000, 0, 3'b000, 1, 8'h42, 1, 1));
      tbl.push_back(mk(1, 3'b000, 3'b000, 1, 3'b000, 0, 8'h42, 1, 1));
      tbl.push_back(mk(1, 3'b100, 3'b000, 0, 3'b000, 0, 8'h42, 1, 1));
      tbl.push_back(mk(1, 3'b100, 3'b000, 0, 3'b000, 0, 8'h42, 1, 1));
      tbl.push_back(mk(1, 3'b110, 3'b010, 0, 3'b010, 0, 8'h42, 1, 1));
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst_n = tbl[i].rst_n;
         bus.req_valid = tbl[i].valid;
         bus.req_last = tbl[i].last;
         tb_busy = tbl[i].busy;
         #1;
         vectors++;
         if (bus.req_ready !== tbl[i].ready || bus.tx_start !== tbl[i].start || bus.tx_data !== tbl[i].data ||
             bus.grant_id !== tbl[i].gid || bus.locked !== tbl[i].locked) begin
            fails++;
            $display("FAIL vec%0d: got ready=%b start=%b data=%h gid=%0d locked=%b, expected ready=%b start=%b data=%h gid=%0d locked=%b",
                     i, bus.req_ready, bus.tx_start, bus.tx_data, bus.grant_id, bus.locked,
                     tbl[i].ready, tbl[i].start, tbl[i].data, tbl[i].gid, tbl[i].locked);
         end
      end
      tb_busy = 1'b0;
      model_en = 1'b1;
      // fairness: all valid, single-byte messages
      do_reset();
      bus.req_valid = 3'b111;
      bus.req_last = 3'b111;
      wait_sent(6, 400, "fair_count");
      bus.req_valid = '0;
      for (int i = 0; i < 6; i++) check($sformatf("fair_byte%0d", i), sent_at(i), fair_exp[i]);
      wait_idle(100, "fair_idle");
      // lock: req1 sends a 3-byte message while req0 waits
      do_reset();
      bus.req_data = {8'h00, 8'h41, 8'h30};
      bus.req_valid = 3'b010;
      bus.req_last = 3'b000;
      wait_ready(1, 5, "lock_a");
      bus.req_data = {8'h00, 8'h42, 8'h30};
      bus.req_valid = 3'b011;
      bus.req_last = 3'b001;
      wait_ready(1, 60, "lock_b");
      bus.req_data = {8'h00, 8'h43, 8'h30};
      bus.req_last = 3'b011;
      wait_ready(1, 60, "lock_c");
      bus.req_valid = 3'b001;
      wait_ready(0, 60, "lock_r0");
      bus.req_valid = '0;
      wait_sent(4, 100, "lock_count");
      for (int i = 0; i < 4; i++) check($sformatf("lock_byte%0d", i), sent_at(i), lock_exp[i]);
      wait_idle(100, "lock_idle");
      // busy never rises: start re-pulsed every 16 cycles with the same byte
      model_en = 1'b0;
      do_reset();
      bus.req_data = {8'h00, 8'h00, 8'h55};
      bus.req_valid = 3'b001;
      bus.req_last = 3'b001;
      wait_ready(0, 5, "tmo_accept");
      bus.req_valid = '0;
      for (int k = 0; k <= 40; k++) begin
         #1;
         vectors++;
         if (bus.tx_start !== (k % 16 == 0) || bus.tx_data !== 8'h55) begin
            fails++;
            $display("FAIL tmo_k%0d: got start=%b data=%h, expected start=%b data=55",
                     k, bus.tx_start, bus.tx_data, (k % 16 == 0));
         end
         @(negedge clk);
      end
      model_en = 1'b1;
      wait_idle(80, "tmo_idle");
      check("tmo_pulses", sent.size(), 4);
      check("tmo_last_byte", sent_at(3), 8'h55);
      // reset during WAIT_DONE, then req0 beats req2
      do_reset();
      bus.req_data = {8'h43, 8'h42, 8'h41};
      bus.req_valid = 3'b010;
      bus.req_last = 3'b010;
      wait_ready(1, 5, "rst_accept");
      bus.req_valid = '0;
      for (int c = 0; c < 10 && !bus.tx_busy; c++) @(negedge clk);
      check("rst_busy_seen", bus.tx_busy, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("rst_outputs", {bus.req_ready, bus.tx_start, bus.tx_data, bus.grant_id, bus.locked}, 0);
      sent.delete();
      rst_n = 1'b1;
      bus.req_valid = 3'b101;
      bus.req_last = 3'b101;
      #1;
      check("rst_first_grant", bus.req_ready, 3'b001);
      wait_ready(0, 5, "rst_r0");
      bus.req_valid = 3'b100;
      wait_ready(2, 80, "rst_r2");
      bus.req_valid = '0;
      wait_sent(2, 80, "rst_count");
      check("rst_byte0", sent_at(0), 8'h41);
      check("rst_byte1", sent_at(1), 8'h43);
      wait_idle(80, "rst_idle");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
